// File: rtl/calc_stage_sequencer.sv
// Stage sequencer for the calculator front end: debounces the ADVANCE/BACK keys,
// steps a stage index and issues write (press) / clear (release) strobes.
module calc_stage_sequencer #(
    parameter int NUM_STAGES      = 4,
    parameter int STAGE_W         = $clog2(NUM_STAGES),
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit WRAP            = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  key_adv_n,
    input  logic                  key_back_n,
    output logic [STAGE_W-1:0]    stage,
    output logic                  write,
    output logic                  clear,
    output logic [NUM_STAGES-1:0] stage_led,
    output logic                  at_last
);

    localparam int                 CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [STAGE_W-1:0] LAST    = STAGE_W'(NUM_STAGES - 1);
    localparam int                 ADV     = 0;
    localparam int                 BACK    = 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADV_HELD  = 2'd1,
        BACK_HELD = 2'd2
    } state_t;

    logic [1:0]         sync1_q, sync1_d;
    logic [1:0]         sync2_q, sync2_d;
    logic [1:0]         deb_q, deb_d;
    logic [CNT_W-1:0]   cnt_q [2];
    logic [CNT_W-1:0]   cnt_d [2];
    state_t             state_q, state_d;
    logic [STAGE_W-1:0] stage_q, stage_d;
    logic [STAGE_W-1:0] stage_next, stage_prev;
    logic               write_q, write_d;
    logic               clear_q, clear_d;

    // Bit 0 carries ADVANCE, bit 1 carries BACK through the synchroniser and debouncer.
    always_comb begin
        sync1_d = {key_back_n, key_adv_n};
        sync2_d = sync1_q;
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            deb_d[k] = deb_q[k];
            cnt_d[k] = '0;
            if (sync2_q[k] != deb_q[k]) begin
                if (cnt_q[k] == CNT_MAX) begin
                    deb_d[k] = ~deb_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        if (stage_q == LAST) begin
            stage_next = WRAP ? '0 : LAST;
        end else begin
            stage_next = stage_q + STAGE_W'(1);
        end
        if (stage_q == '0) begin
            stage_prev = WRAP ? LAST : '0;
        end else begin
            stage_prev = stage_q - STAGE_W'(1);
        end
    end

    // ADVANCE has priority in IDLE; the other key is ignored while one is held.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        write_d = 1'b0;
        clear_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!deb_q[ADV]) begin
                    write_d = 1'b1;
                    state_d = ADV_HELD;
                end else if (!deb_q[BACK]) begin
                    state_d = BACK_HELD;
                end
            end
            ADV_HELD: begin
                if (deb_q[ADV]) begin
                    stage_d = stage_next;
                    clear_d = 1'b1;
                    state_d = IDLE;
                end
            end
            BACK_HELD: begin
                if (deb_q[BACK]) begin
                    stage_d = stage_prev;
                    clear_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            deb_q   <= 2'b11;
            for (int k = 0; k < 2; k++) begin
                cnt_q[k] <= '0;
            end
            state_q <= IDLE;
            stage_q <= '0;
            write_q <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            for (int k = 0; k < 2; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            state_q <= state_d;
            stage_q <= stage_d;
            write_q <= write_d;
            clear_q <= clear_d;
        end
    end

    assign stage     = stage_q;
    assign write     = write_q;
    assign clear     = clear_q;
    assign stage_led = NUM_STAGES'(1) << stage_q;
    assign at_last   = (stage_q == LAST);

endmodule

// File: tb/tb_calc_stage_sequencer.sv
// Bench for calc_stage_sequencer: a wrapping and a saturating instance share the keys
// and are compared every cycle against a behavioural model, plus directed checks.
module tb_calc_stage_sequencer;

    localparam int D    = 4;
    localparam int N    = 4;
    localparam int HIST = 4096;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       key_adv_n = 1'b1;
    logic       key_back_n = 1'b1;

    logic [1:0] stage_w, stage_s;
    logic       write_w, write_s, clear_w, clear_s, last_w, last_s;
    logic [3:0] led_w, led_s;
    logic [8:0] obs_v [2];

    int n_cmp = 0;
    int n_bad = 0;

    calc_stage_sequencer #(.NUM_STAGES(N), .DEBOUNCE_CYCLES(D), .WRAP(1'b1)) u_wrap (
        .CLK(CLK), .RST(RST), .key_adv_n(key_adv_n), .key_back_n(key_back_n),
        .stage(stage_w), .write(write_w), .clear(clear_w), .stage_led(led_w), .at_last(last_w)
    );

    calc_stage_sequencer #(.NUM_STAGES(N), .DEBOUNCE_CYCLES(D), .WRAP(1'b0)) u_sat (
        .CLK(CLK), .RST(RST), .key_adv_n(key_adv_n), .key_back_n(key_back_n),
        .stage(stage_s), .write(write_s), .clear(clear_s), .stage_led(led_s), .at_last(last_s)
    );

    always #5 CLK = ~CLK;

    assign obs_v[0] = {stage_w, write_w, clear_w, led_w, last_w};
    assign obs_v[1] = {stage_s, write_s, clear_s, led_s, last_s};

    // Reference model: a key level is accepted once the raw key, seen two cycles late,
    // has disagreed with the accepted level for D consecutive cycles.
    bit raw_hist [2][HIST];
    bit deb [2];
    int mode [2];
    int exp_stage [2];
    bit exp_write [2];
    bit exp_clear [2];
    int e = 0;

    function automatic bit late_key(int k, int j);
        if (j < 3 || j - 2 >= HIST) return 1'b1;
        return raw_hist[k][j-2];
    endfunction

    function automatic int next_stage(int s, int w);
        if (w == 0) return (s + 1) % N;
        return (s == N - 1) ? s : s + 1;
    endfunction

    function automatic int prev_stage(int s, int w);
        if (w == 0) return (s + N - 1) % N;
        return (s == 0) ? 0 : s - 1;
    endfunction

    function automatic logic [8:0] exp_vec(int w);
        logic [1:0] s;
        s = exp_stage[w][1:0];
        return {s, exp_write[w], exp_clear[w], 4'b0001 << s, exp_stage[w] == N - 1};
    endfunction

    always @(posedge CLK) begin
        bit nd [2];
        bit all_diff;
        if (RST) begin
            e = 0;
            for (int k = 0; k < 2; k++) deb[k] = 1'b1;
            for (int w = 0; w < 2; w++) begin
                mode[w] = 0;
                exp_stage[w] = 0;
                exp_write[w] = 1'b0;
                exp_clear[w] = 1'b0;
            end
        end else begin
            e++;
            if (e < HIST) begin
                raw_hist[0][e] = key_adv_n;
                raw_hist[1][e] = key_back_n;
            end
            for (int w = 0; w < 2; w++) begin
                exp_write[w] = 1'b0;
                exp_clear[w] = 1'b0;
                if (mode[w] == 0) begin
                    if (!deb[0]) begin
                        exp_write[w] = 1'b1;
                        mode[w] = 1;
                    end else if (!deb[1]) begin
                        mode[w] = 2;
                    end
                end else if (mode[w] == 1) begin
                    if (deb[0]) begin
                        exp_stage[w] = next_stage(exp_stage[w], w);
                        exp_clear[w] = 1'b1;
                        mode[w] = 0;
                    end
                end else begin
                    if (deb[1]) begin
                        exp_stage[w] = prev_stage(exp_stage[w], w);
                        exp_clear[w] = 1'b1;
                        mode[w] = 0;
                    end
                end
            end
            for (int k = 0; k < 2; k++) begin
                all_diff = 1'b1;
                for (int j = e - D + 1; j <= e; j++) begin
                    if (late_key(k, j) == deb[k]) all_diff = 1'b0;
                end
                nd[k] = all_diff ? !deb[k] : deb[k];
            end
            deb[0] = nd[0];
            deb[1] = nd[1];
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        key_adv_n = 1'b1;
        key_back_n = 1'b1;
        tick();
        tick();
        for (int w = 0; w < 2; w++) begin
            n_cmp++;
            if (obs_v[w] !== 9'b00_0_0_0001_0) begin
                n_bad++;
                $display("[TB] FAIL reset_state dut%0d got %b want %b", w, obs_v[w], 9'b00_0_0_0001_0);
            end
        end
        RST = 1'b0;
    endtask

    task automatic test_single_press();
        int first_w;
        int first_c;
        int nw;
        int nc;
        first_w = -1;
        first_c = -1;
        nw = 0;
        nc = 0;
        key_adv_n = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            for (int w = 0; w < 2; w++) begin
                n_cmp++;
                if (obs_v[w] !== exp_vec(w)) begin
                    n_bad++;
                    $display("[TB] FAIL press_model dut%0d t=%0t got %b want %b", w, $time, obs_v[w], exp_vec(w));
                end
            end
            if (write_w) begin nw++; if (first_w < 0) first_w = i; end
            if (clear_w) nc++;
        end
        key_adv_n = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            for (int w = 0; w < 2; w++) begin
                n_cmp++;
                if (obs_v[w] !== exp_vec(w)) begin
                    n_bad++;
                    $display("[TB] FAIL release_model dut%0d t=%0t got %b want %b", w, $time, obs_v[w], exp_vec(w));
                end
            end
            if (write_w) nw++;
            if (clear_w) begin nc++; if (first_c < 0) first_c = i; end
        end
        n_cmp++;
        if (first_w !== 7) begin n_bad++; $display("[TB] FAIL write_latency got %0d want 7", first_w); end
        n_cmp++;
        if (first_c !== 7) begin n_bad++; $display("[TB] FAIL clear_latency got %0d want 7", first_c); end
        n_cmp++;
        if (nw !== 1 || nc !== 1) begin n_bad++; $display("[TB] FAIL strobe_count got w=%0d c=%0d want 1/1", nw, nc); end
        n_cmp++;
        if (stage_w !== 2'd1 || led_w !== 4'b0010) begin
            n_bad++;
            $display("[TB] FAIL stage_after_press got %0d/%b want 1/0010", stage_w, led_w);
        end
    endtask

    task automatic test_glitch();
        int ns;
        ns = 0;
        key_adv_n = 1'b0;
        for (int i = 0; i < 43; i++) begin
            if (i == D - 1) key_adv_n = 1'b1;
            if (i >= 13 && i < 23) key_adv_n = i[0];
            if (i == 23) key_adv_n = 1'b1;
            tick();
            for (int w = 0; w < 2; w++) begin
                n_cmp++;
                if (obs_v[w] !== exp_vec(w)) begin
                    n_bad++;
                    $display("[TB] FAIL glitch_model dut%0d t=%0t got %b want %b", w, $time, obs_v[w], exp_vec(w));
                end
            end
            if (write_w || clear_w || write_s || clear_s) ns++;
        end
        n_cmp++;
        if (ns !== 0) begin n_bad++; $display("[TB] FAIL glitch_strobes got %0d want 0", ns); end
        n_cmp++;
        if (stage_w !== 2'd1) begin n_bad++; $display("[TB] FAIL glitch_stage got %0d want 1", stage_w); end
    endtask

    task automatic test_wrap_saturate();
        int wrap_seq [4];
        int sat_seq [4];
        int nw_w;
        int nw_s;
        wrap_seq = '{1, 2, 3, 0};
        sat_seq  = '{1, 2, 3, 3};
        nw_w = 0;
        nw_s = 0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 24; i++) begin
                key_adv_n = (i >= 12);
                tick();
                for (int w = 0; w < 2; w++) begin
                    n_cmp++;
                    if (obs_v[w] !== exp_vec(w)) begin
                        n_bad++;
                        $display("[TB] FAIL wrap_model dut%0d t=%0t got %b want %b", w, $time, obs_v[w], exp_vec(w));
                    end
                end
                if (write_w) nw_w++;
                if (write_s) nw_s++;
            end
            n_cmp++;
            if (stage_w !== 2'(wrap_seq[p]) || last_w !== (wrap_seq[p] == 3)) begin
                n_bad++;
                $display("[TB] FAIL wrap_stage press%0d got %0d/%b want %0d", p, stage_w, last_w, wrap_seq[p]);
            end
            n_cmp++;
            if (stage_s !== 2'(sat_seq[p]) || last_s !== (sat_seq[p] == 3)) begin
                n_bad++;
                $display("[TB] FAIL sat_stage press%0d got %0d/%b want %0d", p, stage_s, last_s, sat_seq[p]);
            end
        end
        n_cmp++;
        if (nw_w !== 4 || nw_s !== 4) begin
            n_bad++;
            $display("[TB] FAIL wrap_writes got %0d/%0d want 4/4", nw_w, nw_s);
        end
    endtask

    task automatic test_back_and_priority();
        int nw;
        int nc;
        nw = 0;
        nc = 0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int i = 0; i < 24; i++) begin
            key_back_n = (i >= 12);
            tick();
            for (int w = 0; w < 2; w++) begin
                n_cmp++;
                if (obs_v[w] !== exp_vec(w)) begin
                    n_bad++;
                    $display("[TB] FAIL back_model dut%0d t=%0t got %b want %b", w, $time, obs_v[w], exp_vec(w));
                end
            end
            if (write_w || write_s) nw++;
            if (clear_w) nc++;
        end
        n_cmp++;
        if (nw !== 0 || nc !== 1) begin n_bad++; $display("[TB] FAIL back_strobes got w=%0d c=%0d want 0/1", nw, nc); end
        n_cmp++;
        if (stage_w !== 2'd3 || stage_s !== 2'd0) begin
            n_bad++;
            $display("[TB] FAIL back_stage got %0d/%0d want 3/0", stage_w, stage_s);
        end
        nw = 0;
        for (int i = 0; i < 24; i++) begin
            key_adv_n = (i >= 12);
            key_back_n = (i >= 12);
            tick();
            for (int w = 0; w < 2; w++) begin
                n_cmp++;
                if (obs_v[w] !== exp_vec(w)) begin
                    n_bad++;
                    $display("[TB] FAIL both_model dut%0d t=%0t got %b want %b", w, $time, obs_v[w], exp_vec(w));
                end
            end
            if (write_w) nw++;
        end
        n_cmp++;
        if (nw !== 1 || stage_w !== 2'd0 || stage_s !== 2'd1) begin
            n_bad++;
            $display("[TB] FAIL both_keys got w=%0d stage=%0d/%0d want 1 0/1", nw, stage_w, stage_s);
        end
    endtask

    task automatic test_reset_mid_press();
        int first_w;
        int nc;
        first_w = -1;
        nc = 0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int i = 0; i < 36; i++) begin
            key_adv_n = (i >= 12 && i < 24);
            tick();
            for (int w = 0; w < 2; w++) begin
                n_cmp++;
                if (obs_v[w] !== exp_vec(w)) begin
                    n_bad++;
                    $display("[TB] FAIL hold_model dut%0d t=%0t got %b want %b", w, $time, obs_v[w], exp_vec(w));
                end
            end
        end
        RST = 1'b1;
        tick();
        for (int w = 0; w < 2; w++) begin
            n_cmp++;
            if (obs_v[w] !== 9'b00_0_0_0001_0) begin
                n_bad++;
                $display("[TB] FAIL midpress_reset dut%0d got %b want %b", w, obs_v[w], 9'b00_0_0_0001_0);
            end
        end
        RST = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            for (int w = 0; w < 2; w++) begin
                n_cmp++;
                if (obs_v[w] !== exp_vec(w)) begin
                    n_bad++;
                    $display("[TB] FAIL rehold_model dut%0d t=%0t got %b want %b", w, $time, obs_v[w], exp_vec(w));
                end
            end
            if (write_w && first_w < 0) first_w = i;
            if (clear_w) nc++;
        end
        n_cmp++;
        if (first_w !== 7 || nc !== 0) begin
            n_bad++;
            $display("[TB] FAIL rewrite_after_reset got write@%0d clears=%0d want 7/0", first_w, nc);
        end
        key_adv_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        n_cmp++;
        if (stage_w !== 2'd1) begin n_bad++; $display("[TB] FAIL stage_after_rehold got %0d want 1", stage_w); end
    endtask

    task automatic test_random();
        int len;
        bit rst_seg;
        for (int seg = 0; seg < 60; seg++) begin
            key_adv_n = 1'($urandom_range(0, 1));
            key_back_n = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 14);
            rst_seg = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < len; i++) begin
                RST = rst_seg && (i == 0);
                tick();
                for (int w = 0; w < 2; w++) begin
                    n_cmp++;
                    if (obs_v[w] !== exp_vec(w)) begin
                        n_bad++;
                        $display("[TB] FAIL random_model dut%0d t=%0t got %b want %b", w, $time, obs_v[w], exp_vec(w));
                    end
                end
            end
            RST = 1'b0;
        end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_single_press();
        test_glitch();
        test_wrap_saturate();
        test_back_and_priority();
        test_reset_mid_press();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
